// File: rtl/or_gate_exerciser.sv
// ---------------------------------------------------------------------------
// or_gate_exerciser
//   Drives every operand combination into an external N-bit OR gate. After
//   each pair of operands has been held for a settle window, the block samples
//   the gate output, compares it with a|b and counts the mismatches.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a sweep (only acted on in IDLE or DONE)
//   a, b       operands to the gate under test ({a,b} == vec_index)
//   s          result returned by the gate under test
//   busy       high in DRIVE, SETTLE, CHECK
//   log_valid  one-cycle strobe in CHECK; a, b, s, mismatch are valid
//   mismatch   in CHECK: s != (a|b); 0 otherwise
//   vec_index  current vector number, 0 .. 2^(2N)-1
//   err_count  mismatches seen during this sweep
//   done       high while in DONE
//   pass       high in DONE when err_count == 0
// ---------------------------------------------------------------------------
module or_gate_exerciser #(
  parameter int N      = 1,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [N-1:0]   a,
  output logic [N-1:0]   b,
  input  logic [N-1:0]   s,
  output logic           busy,
  output logic           log_valid,
  output logic           mismatch,
  output logic [2*N-1:0] vec_index,
  output logic [2*N:0]   err_count,
  output logic           done,
  output logic           pass
);

  // The settle counter only ever holds SETTLE-1 down to 0.
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);
  localparam logic [2*N-1:0]  LAST_VEC = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [2*N-1:0]  vec_nxt;
  logic [2*N:0]    err_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N-1:0]    expected;

  // Operands are slices of the vector register, so they only move when
  // vec_index does: at entry to DRIVE (or on reset).
  assign a        = vec_index[2*N-1:N];
  assign b        = vec_index[N-1:0];
  assign expected = a | b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      vec_index <= '0;
      err_count <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      vec_index <= vec_nxt;
      err_count <= err_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_index;
    err_nxt   = err_count;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    log_valid = 1'b0;
    mismatch  = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_DRIVE;
          vec_nxt   = '0;
          err_nxt   = '0;
        end
      end

      S_DRIVE: begin
        busy      = 1'b1;
        state_nxt = S_SETTLE;
        cnt_nxt   = CNT_INIT;
      end

      // Stays here exactly SETTLE cycles: entered with SETTLE-1, exits at 0.
      S_SETTLE: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = S_CHECK;
        else           cnt_nxt   = cnt - CW'(1);
      end

      S_CHECK: begin
        busy      = 1'b1;
        log_valid = 1'b1;
        mismatch  = (s != expected);
        // 2N+1 bits can hold 2^(2N) errors, so no saturation is required.
        if (mismatch) err_nxt = err_count + (2*N+1)'(1);
        if (vec_index == LAST_VEC) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_DRIVE;
          vec_nxt   = vec_index + (2*N)'(1);
        end
      end

      // Results hold here until the next sweep is requested.
      S_DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (start) begin
          state_nxt = S_DRIVE;
          vec_nxt   = '0;
          err_nxt   = '0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
